// File: rtl/multicycle_pkg.sv
// Shared state, opcode and datapath-select encodings for the multicycle controller.
package multicycle_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StFault
  } state_t;

  // instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  // RegSrc[0]: read PC as Rn (branch); RegSrc[1]: read Rd as Rm (store data)
  localparam logic [1:0] REGSRC_DP  = 2'b00;
  localparam logic [1:0] REGSRC_MEM = 2'b10;
  localparam logic [1:0] REGSRC_BR  = 2'b01;

  // States that sit on the memory handshake and feed the timeout counter.
  function automatic logic is_wait_state(state_t s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/mc_output_rom.sv
// Combinational map from controller state (plus Op and mem_ready) to every datapath
// select and strobe. All outputs are 0 unless active is set.
module mc_output_rom
  import multicycle_pkg::*;
(
  input  state_t     state,
  input  logic       active,
  input  logic [1:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemW,
  output logic       RegW,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       ALUOp,
  output logic       fault
);

  always_comb begin
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    MemW      = 1'b0;
    RegW      = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    ImmSrc    = IMM_DP;
    RegSrc    = REGSRC_DP;
    ALUOp     = 1'b0;
    fault     = 1'b0;
    if (active) begin
      case (state)
        StFetch: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALU;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        StDecode: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALU;
          // Illegal Op leaves ImmSrc/RegSrc at the DP encoding.
          case (op)
            OP_MEM: begin
              ImmSrc = IMM_MEM;
              RegSrc = REGSRC_MEM;
            end
            OP_BR: begin
              ImmSrc = IMM_BR;
              RegSrc = REGSRC_BR;
            end
            default: ;
          endcase
        end
        StMemAdr: ALUSrcB = SRCB_IMM;
        StMemRd:  AdrSrc  = 1'b1;
        StMemWb: begin
          ResultSrc = RES_RDATA;
          RegW      = 1'b1;
        end
        StMemWr: begin
          AdrSrc = 1'b1;
          MemW   = mem_ready;
        end
        StExecR: ALUOp = 1'b1;
        StExecI: begin
          ALUSrcB = SRCB_IMM;
          ALUOp   = 1'b1;
        end
        StAluWb: RegW = 1'b1;
        StBranch: begin
          ALUSrcB   = SRCB_IMM;
          ResultSrc = RES_ALU;
          PCWrite   = 1'b1;
        end
        StFault: fault = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control FSM: state register, memory timeout and optional
// performance counters (enabled by MULTICYCLE_PERF_CNT_EN).
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  Op,
  input  logic        Funct5,
  input  logic        Funct0,
  input  logic        cond_ex,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemW,
  output logic        RegW,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        ALUOp,
  output logic        fault,
  output logic [31:0] instr_count,
  output logic [31:0] cycle_count
);

  state_t     state_q, state_d;
  logic [7:0] tmo_q, tmo_d;
  // Low through reset and the release cycle, so nothing pulses until the first edge after release.
  logic       run_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFetch;
      tmo_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    if (run_q) begin
      case (state_q)
        StFetch:  if (mem_ready) state_d = StDecode;
        StDecode: begin
          if (Op == OP_ILL)     state_d = StFault;
          else if (!cond_ex)    state_d = StFetch;
          else if (Op == OP_DP) state_d = Funct5 ? StExecI : StExecR;
          else if (Op == OP_MEM) state_d = StMemAdr;
          else                  state_d = StBranch;
        end
        StMemAdr: state_d = Funct0 ? StMemRd : StMemWr;
        StMemRd:  if (mem_ready) state_d = StMemWb;
        StMemWr:  if (mem_ready) state_d = StFetch;
        StExecR, StExecI: state_d = StAluWb;
        StMemWb, StAluWb, StBranch: state_d = StFetch;
        StFault:  state_d = StFault;
        default:  state_d = StFault;
      endcase
      if (is_wait_state(state_q) && !mem_ready) begin
        tmo_d = tmo_q + 8'd1;
        if (tmo_d == 8'(MEM_TIMEOUT)) state_d = StFault;
      end
    end
  end

  mc_output_rom u_rom (
    .state     (state_q),
    .active    (run_q),
    .op        (Op),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .IRWrite   (IRWrite),
    .MemW      (MemW),
    .RegW      (RegW),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ImmSrc    (ImmSrc),
    .RegSrc    (RegSrc),
    .ALUOp     (ALUOp),
    .fault     (fault)
  );

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] icnt_q, ccnt_q;
  logic        retire;

  // Every retiring state only ever leaves towards FETCH, and DECODE only does so on cond fail.
  assign retire = (state_d == StFetch) &&
                  ((state_q == StMemWb) || (state_q == StMemWr) || (state_q == StAluWb) ||
                   (state_q == StBranch) || (state_q == StDecode));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      icnt_q <= '0;
      ccnt_q <= '0;
    end else begin
      if (run_q && (state_q != StFault)) ccnt_q <= ccnt_q + 32'd1;
      if (run_q && retire)               icnt_q <= icnt_q + 32'd1;
    end
  end

  assign instr_count = icnt_q;
  assign cycle_count = ccnt_q;
`else
  assign instr_count = '0;
  assign cycle_count = '0;
`endif

endmodule
